sprite_line_scanner: RTL and testbench

Read-side client of the 256x32 sprite attribute RAM. At the start of every display line it walks all 128 sprite entries (two words each), selects the sprites that have non-zero Z depth and vertically intersect the requested line, and hands each hit to the sprite renderer over a valid/ready stream. It sits in the video clock domain, between the sprite attribute RAM read port and the sprite pixel renderer.

---
 rtl/sprite_line_scanner_pkg.sv | 56 +++++
 rtl/sprite_line_hit.sv | 23 ++
 rtl/sprite_line_scanner.sv | 254 +++++++++++++++++++++++++
 tb/tb_sprite_line_scanner.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_line_scanner_pkg.sv
// Shared definitions for the sprite line scanner: attribute word field
// positions, table geometry, scan FSM encoding and the height-code decode.
package sprite_line_scanner_pkg;

  localparam int NUM_SPRITES      = 128;
  localparam int WORDS_PER_SPRITE = 2;
  localparam int IDX_W            = $clog2(NUM_SPRITES);
  localparam int ADDR_W           = $clog2(NUM_SPRITES * WORDS_PER_SPRITE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

  // word0 fields
  localparam int W0_ADDR_LSB = 0;
  localparam int W0_ADDR_MSB = 11;
  localparam int W0_MODE_BIT = 15;
  localparam int W0_X_LSB    = 16;
  localparam int W0_X_MSB    = 25;

  // word1 fields
  localparam int W1_Y_LSB     = 0;
  localparam int W1_Y_MSB     = 9;
  localparam int W1_HFLIP_BIT = 16;
  localparam int W1_VFLIP_BIT = 17;
  localparam int W1_Z_LSB     = 18;
  localparam int W1_Z_MSB     = 19;
  localparam int W1_COLL_LSB  = 20;
  localparam int W1_COLL_MSB  = 23;
  localparam int W1_PAL_LSB   = 24;
  localparam int W1_PAL_MSB   = 27;
  localparam int W1_WIDTH_LSB = 28;
  localparam int W1_WIDTH_MSB = 29;
  localparam int W1_H_LSB     = 30;
  localparam int W1_H_MSB     = 31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR0 = 3'd1,
    ST_ADDR1 = 3'd2,
    ST_EVAL  = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } scan_state_e;

  // Sprite height in lines for a 2-bit height code (8 << h).
  function automatic logic [9:0] height_decode(input logic [1:0] h_code);
    logic [9:0] height;
    case (h_code)
      2'd0:    height = 10'd8;
      2'd1:    height = 10'd16;
      2'd2:    height = 10'd32;
      2'd3:    height = 10'd64;
      default: height = 10'd8;
    endcase
    return height;
  endfunction

endpackage

// File: rtl/sprite_line_hit.sv
// Vertical intersection test for one sprite: wrap-around distance from the
// sprite top to the requested line, hit flag and row within the sprite.
module sprite_line_hit
  import sprite_line_scanner_pkg::*;
(
  input  logic [9:0] line_i,
  input  logic [9:0] y_i,
  input  logic [1:0] h_i,
  input  logic [1:0] z_i,
  output logic       hit_o,
  output logic [5:0] row_o
);

  logic [9:0] diff_s;

  // Modulo-1024 distance so sprites straddling the bottom edge wrap to the top.
  always_comb begin
    diff_s = line_i - y_i;
    hit_o  = (z_i != 2'd0) && (diff_s < height_decode(h_i));
    row_o  = diff_s[5:0];
  end

endmodule

// File: rtl/sprite_line_scanner.sv
// Per-line sprite attribute scanner: walks all sprite entries in the
// attribute RAM, emits each sprite intersecting the line over valid/ready.
// Optional macro SPRITE_LINE_LIMIT_EN caps accepted records at MAX_HITS.
module sprite_line_scanner
  import sprite_line_scanner_pkg::*;
#(
  parameter int MAX_HITS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        line_start_i,
  input  logic [9:0]  line_i,
  input  logic        sprites_en_i,
  output logic        rd_en_o,
  output logic [7:0]  rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        spr_valid_o,
  input  logic        spr_ready_i,
  output logic [6:0]  spr_idx_o,
  output logic [11:0] spr_addr_o,
  output logic        spr_mode_o,
  output logic [9:0]  spr_x_o,
  output logic [5:0]  spr_row_o,
  output logic        spr_hflip_o,
  output logic        spr_vflip_o,
  output logic [1:0]  spr_z_o,
  output logic [3:0]  spr_coll_o,
  output logic [3:0]  spr_pal_o,
  output logic [1:0]  spr_width_o,
  output logic        busy_o,
  output logic        scan_done_o
);

  scan_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [9:0]        line_q, line_d;
  logic [31:0]       word0_q, word0_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              spr_valid_q, spr_valid_d;
  logic [6:0]        spr_idx_q, spr_idx_d;
  logic [11:0]       spr_addr_q, spr_addr_d;
  logic              spr_mode_q, spr_mode_d;
  logic [9:0]        spr_x_q, spr_x_d;
  logic [5:0]        spr_row_q, spr_row_d;
  logic              spr_hflip_q, spr_hflip_d;
  logic              spr_vflip_q, spr_vflip_d;
  logic [1:0]        spr_z_q, spr_z_d;
  logic [3:0]        spr_coll_q, spr_coll_d;
  logic [3:0]        spr_pal_q, spr_pal_d;
  logic [1:0]        spr_width_q, spr_width_d;
  logic              busy_q, busy_d;
  logic              scan_done_q, scan_done_d;
  logic              advance_s;
  logic              hit_s;
  logic [5:0]        row_s;
  logic              unused_word0_s;

`ifdef SPRITE_LINE_LIMIT_EN
  localparam logic [7:0] HIT_LIMIT = 8'(MAX_HITS);
  logic [7:0] hits_q, hits_d;
`else
  logic [7:0] unused_max_hits_s;
  assign unused_max_hits_s = 8'(MAX_HITS);
`endif

  // Reserved word0 bits carry no sprite attribute.
  assign unused_word0_s = ^{word0_q[31:26], word0_q[14:12]};

  // word1 is evaluated straight off the RAM data bus during EVAL.
  sprite_line_hit u_hit (
    .line_i (line_q),
    .y_i    (rd_data_i[W1_Y_MSB:W1_Y_LSB]),
    .h_i    (rd_data_i[W1_H_MSB:W1_H_LSB]),
    .z_i    (rd_data_i[W1_Z_MSB:W1_Z_LSB]),
    .hit_o  (hit_s),
    .row_o  (row_s)
  );

  // Scan sequencing: state walk, sprite stepping, record capture, abort/restart.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    line_d      = line_q;
    word0_d     = word0_q;
    advance_s   = 1'b0;
    spr_idx_d   = spr_idx_q;
    spr_addr_d  = spr_addr_q;
    spr_mode_d  = spr_mode_q;
    spr_x_d     = spr_x_q;
    spr_row_d   = spr_row_q;
    spr_hflip_d = spr_hflip_q;
    spr_vflip_d = spr_vflip_q;
    spr_z_d     = spr_z_q;
    spr_coll_d  = spr_coll_q;
    spr_pal_d   = spr_pal_q;
    spr_width_d = spr_width_q;
`ifdef SPRITE_LINE_LIMIT_EN
    hits_d      = hits_q;
`endif

    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_ADDR0: state_d = ST_ADDR1;
      ST_ADDR1: begin
        word0_d = rd_data_i;
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (hit_s) begin
          state_d     = ST_EMIT;
          spr_idx_d   = idx_q;
          spr_row_d   = row_s;
          spr_addr_d  = word0_q[W0_ADDR_MSB:W0_ADDR_LSB];
          spr_mode_d  = word0_q[W0_MODE_BIT];
          spr_x_d     = word0_q[W0_X_MSB:W0_X_LSB];
          spr_hflip_d = rd_data_i[W1_HFLIP_BIT];
          spr_vflip_d = rd_data_i[W1_VFLIP_BIT];
          spr_z_d     = rd_data_i[W1_Z_MSB:W1_Z_LSB];
          spr_coll_d  = rd_data_i[W1_COLL_MSB:W1_COLL_LSB];
          spr_pal_d   = rd_data_i[W1_PAL_MSB:W1_PAL_LSB];
          spr_width_d = rd_data_i[W1_WIDTH_MSB:W1_WIDTH_LSB];
        end else begin
          advance_s = 1'b1;
        end
      end
      ST_EMIT: begin
        if (spr_ready_i) begin
`ifdef SPRITE_LINE_LIMIT_EN
          hits_d = hits_q + 8'd1;
          if (hits_d == HIT_LIMIT) begin
            state_d = ST_DONE;
          end else begin
            advance_s = 1'b1;
          end
`else
          advance_s = 1'b1;
`endif
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (advance_s) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_DONE;
      end else begin
        idx_d   = idx_q + 7'd1;
        state_d = ST_ADDR0;
      end
    end else begin
      // stay on the current sprite
    end

    // A new line pulse wins over everything, including an in-flight scan.
    if (line_start_i) begin
      line_d  = line_i;
      idx_d   = 7'd0;
`ifdef SPRITE_LINE_LIMIT_EN
      hits_d  = 8'd0;
`endif
      state_d = sprites_en_i ? ST_ADDR0 : ST_DONE;
    end else begin
      line_d = line_q;
    end
  end

  // Registered output decode, aligned with the state being entered.
  always_comb begin
    rd_en_d     = (state_d == ST_ADDR0) || (state_d == ST_ADDR1);
    spr_valid_d = (state_d == ST_EMIT);
    busy_d      = (state_d != ST_IDLE);
    scan_done_d = (state_q == ST_DONE) && !line_start_i;
    case (state_d)
      ST_ADDR0: rd_addr_d = {idx_d, 1'b0};
      ST_ADDR1: rd_addr_d = {idx_d, 1'b1};
      default:  rd_addr_d = rd_addr_q;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= 7'd0;
      line_q      <= 10'd0;
      word0_q     <= 32'd0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 8'd0;
      spr_valid_q <= 1'b0;
      spr_idx_q   <= 7'd0;
      spr_addr_q  <= 12'd0;
      spr_mode_q  <= 1'b0;
      spr_x_q     <= 10'd0;
      spr_row_q   <= 6'd0;
      spr_hflip_q <= 1'b0;
      spr_vflip_q <= 1'b0;
      spr_z_q     <= 2'd0;
      spr_coll_q  <= 4'd0;
      spr_pal_q   <= 4'd0;
      spr_width_q <= 2'd0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
`ifdef SPRITE_LINE_LIMIT_EN
      hits_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      line_q      <= line_d;
      word0_q     <= word0_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      spr_valid_q <= spr_valid_d;
      spr_idx_q   <= spr_idx_d;
      spr_addr_q  <= spr_addr_d;
      spr_mode_q  <= spr_mode_d;
      spr_x_q     <= spr_x_d;
      spr_row_q   <= spr_row_d;
      spr_hflip_q <= spr_hflip_d;
      spr_vflip_q <= spr_vflip_d;
      spr_z_q     <= spr_z_d;
      spr_coll_q  <= spr_coll_d;
      spr_pal_q   <= spr_pal_d;
      spr_width_q <= spr_width_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
`ifdef SPRITE_LINE_LIMIT_EN
      hits_q      <= hits_d;
`endif
    end
  end

  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign spr_valid_o = spr_valid_q;
  assign spr_idx_o   = spr_idx_q;
  assign spr_addr_o  = spr_addr_q;
  assign spr_mode_o  = spr_mode_q;
  assign spr_x_o     = spr_x_q;
  assign spr_row_o   = spr_row_q;
  assign spr_hflip_o = spr_hflip_q;
  assign spr_vflip_o = spr_vflip_q;
  assign spr_z_o     = spr_z_q;
  assign spr_coll_o  = spr_coll_q;
  assign spr_pal_o   = spr_pal_q;
  assign spr_width_o = spr_width_q;
  assign busy_o      = busy_q;
  assign scan_done_o = scan_done_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Self-checking bench for sprite_line_scanner: table of single-sprite line
// vectors plus hand-written stall, abort, disable and hit-limit sequences.
module tb_sprite_line_scanner;

`ifdef SPRITE_LINE_LIMIT_EN
  localparam int TB_MAX_HITS = 4;
`else
  localparam int TB_MAX_HITS = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        line_start_i = 1'b0;
  logic [9:0]  line_i = 10'd0;
  logic        sprites_en_i = 1'b0;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [31:0] rd_data_i;
  logic        spr_valid_o;
  logic        spr_ready_i = 1'b1;
  logic [6:0]  spr_idx_o;
  logic [11:0] spr_addr_o;
  logic        spr_mode_o;
  logic [9:0]  spr_x_o;
  logic [5:0]  spr_row_o;
  logic        spr_hflip_o, spr_vflip_o;
  logic [1:0]  spr_z_o;
  logic [3:0]  spr_coll_o, spr_pal_o;
  logic [1:0]  spr_width_o;
  logic        busy_o, scan_done_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_line_scanner #(.MAX_HITS(TB_MAX_HITS)) dut (
    .clk_i(clk), .rst_i(rst_i), .line_start_i(line_start_i), .line_i(line_i),
    .sprites_en_i(sprites_en_i), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i), .spr_valid_o(spr_valid_o), .spr_ready_i(spr_ready_i),
    .spr_idx_o(spr_idx_o), .spr_addr_o(spr_addr_o), .spr_mode_o(spr_mode_o),
    .spr_x_o(spr_x_o), .spr_row_o(spr_row_o), .spr_hflip_o(spr_hflip_o),
    .spr_vflip_o(spr_vflip_o), .spr_z_o(spr_z_o), .spr_coll_o(spr_coll_o),
    .spr_pal_o(spr_pal_o), .spr_width_o(spr_width_o), .busy_o(busy_o),
    .scan_done_o(scan_done_o)
  );

  // Attribute RAM model, one cycle read latency
  logic [31:0] mem [0:255];
  logic [31:0] rd_q = 32'd0;
  always @(posedge clk) if (rd_en_o) rd_q <= mem[rd_addr_o];
  assign rd_data_i = rd_q;

  typedef struct packed {
    logic [6:0]  idx;
    logic [5:0]  row;
    logic [11:0] addr;
    logic        mode;
    logic [9:0]  x;
    logic        hf;
    logic        vf;
    logic [1:0]  z;
    logic [3:0]  coll;
    logic [3:0]  pal;
    logic [1:0]  width;
  } rec_t;

  typedef struct {
    int         idx;
    logic [9:0] y;
    logic [1:0] h;
    logic [1:0] z;
    logic [9:0] line;
    bit         exp_hit;
    logic [5:0] exp_row;
  } vec_t;

  rec_t recs[$];
  int   acc_n[$];
  int   max_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] make_w0(input int n);
    logic [6:0] i;
    i = 7'(n);
    return {6'h3F, 10'(n * 7), i[0], 3'b111, 12'hA00 | {5'd0, i}};
  endfunction

  function automatic logic [31:0] make_w1(input int n, input logic [9:0] y,
                                          input logic [1:0] h, input logic [1:0] z);
    logic [6:0] i;
    i = 7'(n);
    return {h, i[1:0], ~i[3:0], i[3:0], z, i[2], i[1], 6'h2A, y};
  endfunction

  function automatic rec_t exp_rec(input int n, input logic [5:0] row, input logic [1:0] z);
    rec_t r;
    logic [6:0] i;
    i = 7'(n);
    r.idx = i; r.row = row; r.addr = 12'hA00 | {5'd0, i}; r.mode = i[0];
    r.x = 10'(n * 7); r.hf = i[1]; r.vf = i[2]; r.z = z;
    r.coll = i[3:0]; r.pal = ~i[3:0]; r.width = i[1:0];
    return r;
  endfunction

  function automatic rec_t cur_rec();
    rec_t r;
    r.idx = spr_idx_o; r.row = spr_row_o; r.addr = spr_addr_o; r.mode = spr_mode_o;
    r.x = spr_x_o; r.hf = spr_hflip_o; r.vf = spr_vflip_o; r.z = spr_z_o;
    r.coll = spr_coll_o; r.pal = spr_pal_o; r.width = spr_width_o;
    return r;
  endfunction

  // Background: every sprite would cover lines 0..63 but has z=0.
  task automatic set_bg();
    for (int n = 0; n < 128; n++) begin
      mem[2*n]   = make_w0(n);
      mem[2*n+1] = make_w1(n, 10'd0, 2'd3, 2'd0);
    end
  endtask

  task automatic put(input int n, input logic [9:0] y, input logic [1:0] h, input logic [1:0] z);
    mem[2*n+1] = make_w1(n, y, h, z);
  endtask

  // Pulse line_start and run to scan_done; cyc counts cycles from the pulse edge.
  task automatic run_scan(input logic [9:0] ln, input logic en, input int stall,
                          output int cyc, output int held, output int unstable, output int extra);
    int   stall_left;
    int   n;
    rec_t snap;
    stall_left = stall; held = 0; unstable = 0; extra = 0; cyc = -1; n = 0; max_rd = -1;
    recs.delete(); acc_n.delete();
    @(posedge clk); #1;
    line_start_i = 1'b1; line_i = ln; sprites_en_i = en; spr_ready_i = 1'b1;
    @(posedge clk); #1;
    line_start_i = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n++;
      if (rd_en_o && (int'(rd_addr_o) > max_rd)) max_rd = int'(rd_addr_o);
      if (spr_valid_o && spr_ready_i) begin
        recs.push_back(cur_rec());
        acc_n.push_back(n);
      end
      if (spr_valid_o && !spr_ready_i) begin
        if (held == 0) snap = cur_rec();
        else if (cur_rec() !== snap) unstable++;
        held++;
      end
      if (scan_done_o) begin
        cyc = n;
        break;
      end
      @(posedge clk); #1;
      if (spr_valid_o && stall_left > 0) begin
        spr_ready_i = 1'b0;
        stall_left--;
      end else begin
        spr_ready_i = 1'b1;
      end
    end
    check("scan_finished", 64'(cyc > 0), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (scan_done_o || spr_valid_o || busy_o) extra++;
    end
  endtask

  vec_t vecs[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, held, unstable, extra, n, done_cnt, valid_seen;

    vecs[0] = '{5,   10'd100,  2'd1, 2'd2, 10'd115, 1'b1, 6'd15};
    vecs[1] = '{5,   10'd100,  2'd1, 2'd2, 10'd116, 1'b0, 6'd0};
    vecs[2] = '{9,   10'd1020, 2'd0, 2'd1, 10'd3,   1'b1, 6'd7};
    vecs[3] = '{9,   10'd1020, 2'd0, 2'd1, 10'd4,   1'b0, 6'd0};
    vecs[4] = '{5,   10'd100,  2'd1, 2'd0, 10'd105, 1'b0, 6'd0};
    vecs[5] = '{64,  10'd200,  2'd3, 2'd3, 10'd263, 1'b1, 6'd63};
    vecs[6] = '{64,  10'd200,  2'd3, 2'd3, 10'd264, 1'b0, 6'd0};
    vecs[7] = '{70,  10'd200,  2'd2, 2'd1, 10'd199, 1'b0, 6'd0};
    vecs[8] = '{127, 10'd0,    2'd0, 2'd1, 10'd0,   1'b1, 6'd0};
    vecs[9] = '{0,   10'd500,  2'd2, 2'd2, 10'd531, 1'b1, 6'd31};

    set_bg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {63'd0, rd_en_o} | {56'd0, rd_addr_o} | {63'd0, spr_valid_o}
          | {63'd0, busy_o} | {63'd0, scan_done_o}, 64'd0);
    check("reset_rec", 64'(cur_rec()), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Full scan with every sprite z=0: no records, done after 386 cycles
    run_scan(10'd10, 1'b1, 0, cyc, held, unstable, extra);
    check("allmiss_records", 64'(recs.size()), 64'd0);
    check("allmiss_cycles", 64'(cyc), 64'd386);
    check("allmiss_quiet", 64'(extra), 64'd0);
    check("allmiss_reads", 64'(max_rd), 64'd255);

    // Single-sprite table
    for (int i = 0; i < 10; i++) begin
      set_bg();
      put(vecs[i].idx, vecs[i].y, vecs[i].h, vecs[i].z);
      run_scan(vecs[i].line, 1'b1, 0, cyc, held, unstable, extra);
      check($sformatf("vec%0d_count", i), 64'(recs.size()), vecs[i].exp_hit ? 64'd1 : 64'd0);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), vecs[i].exp_hit ? 64'd387 : 64'd386);
      check($sformatf("vec%0d_quiet", i), 64'(extra), 64'd0);
      if (vecs[i].exp_hit && recs.size() == 1)
        check($sformatf("vec%0d_rec", i), 64'(recs[0]),
              64'(exp_rec(vecs[i].idx, vecs[i].exp_row, vecs[i].z)));
    end

    // Two hits with a 10-cycle back-pressure stall on the first
    set_bg();
    put(2, 10'd20, 2'd0, 2'd1);
    put(3, 10'd18, 2'd1, 2'd2);
    run_scan(10'd22, 1'b1, 10, cyc, held, unstable, extra);
    check("stall_count", 64'(recs.size()), 64'd2);
    if (recs.size() == 2) begin
      check("stall_first", 64'(recs[0]), 64'(exp_rec(2, 6'd2, 2'd1)));
      check("stall_second", 64'(recs[1]), 64'(exp_rec(3, 6'd4, 2'd2)));
    end
    check("stall_held", 64'(held), 64'd10);
    check("stall_stable", 64'(unstable), 64'd0);
    check("stall_cycles", 64'(cyc), 64'd398);

    // Sprites disabled: straight to done, no reads
    run_scan(10'd22, 1'b0, 0, cyc, held, unstable, extra);
    check("disabled_records", 64'(recs.size()), 64'd0);
    check("disabled_cycles", 64'(cyc), 64'd2);
    check("disabled_reads", 64'(max_rd), 64'hFFFF_FFFF_FFFF_FFFF);

    // Abort with a record pending on sprite 40
    set_bg();
    put(40, 10'd50, 2'd0, 2'd1);
    @(posedge clk); #1;
    line_start_i = 1'b1; line_i = 10'd50; sprites_en_i = 1'b1; spr_ready_i = 1'b0;
    @(posedge clk); #1;
    line_start_i = 1'b0;
    n = 0; done_cnt = 0;
    while (!spr_valid_o && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (scan_done_o) done_cnt++;
    end
    check("abort_pending_valid", 64'(spr_valid_o), 64'd1);
    check("abort_pending_idx", 64'(spr_idx_o), 64'd40);
    repeat (3) @(posedge clk);
    #1;
    line_start_i = 1'b1; line_i = 10'd300;
    @(posedge clk); #1;
    line_start_i = 1'b0; spr_ready_i = 1'b1;
    @(negedge clk);
    check("abort_valid_drop", 64'(spr_valid_o), 64'd0);
    check("abort_restart_addr", {55'd0, rd_en_o, rd_addr_o}, {55'd0, 1'b1, 8'd0});
    n = 1; cyc = -1; valid_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      if (scan_done_o) begin
        cyc = n;
        done_cnt++;
        break;
      end
      if (spr_valid_o) valid_seen++;
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (scan_done_o) done_cnt++;
    end
    check("abort_cycles", 64'(cyc), 64'd386);
    check("abort_done_pulses", 64'(done_cnt), 64'd1);
    check("abort_no_records", 64'(valid_seen), 64'd0);

    // Ten hitting sprites 10..19
    set_bg();
    for (int k = 10; k < 20; k++) put(k, 10'd5, 2'd0, 2'd1);
    run_scan(10'd5, 1'b1, 0, cyc, held, unstable, extra);
`ifdef SPRITE_LINE_LIMIT_EN
    check("limit_count", 64'(recs.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < recs.size()) check($sformatf("limit_idx%0d", k), 64'(recs[k].idx), 64'(10 + k));
    check("limit_cycles", 64'(cyc), 64'd48);
    if (acc_n.size() == 4) check("limit_done_gap", 64'(cyc - acc_n[3]), 64'd2);
    check("limit_reads", 64'(max_rd), 64'd27);
`else
    check("nolimit_count", 64'(recs.size()), 64'd10);
    for (int k = 0; k < 10; k++)
      if (k < recs.size()) check($sformatf("nolimit_idx%0d", k), 64'(recs[k].idx), 64'(10 + k));
    check("nolimit_cycles", 64'(cyc), 64'd396);
    check("nolimit_reads", 64'(max_rd), 64'd255);
`endif
    check("final_quiet", 64'(extra), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
